bsg_link_osdr_phy_multi: RTL and testbench
==========================================

Name: bsg_link_osdr_phy_multi

Overview:
- Multi-channel source-synchronous SDR output PHY for bsg_link.
- Registers a valid/ready-accepted word across channels_p channels, each with its own forwarded clock and valid line.
- Adds link training (a known toggle pattern after reset or on request) and idle clock parking with a wake sequence.
- Sits between the link upstream token/FIFO logic and the IO pads.

Parameters:
- width_p, 16, data bits per channel
- channels_p, 2, number of channels; each has its own clk_o/valid_o
- train_cycles_p, 64, cycles of training pattern per training episode (>=2)
- idle_cycles_p, 16, consecutive idle ACTIVE cycles before parking (>=1)
- wake_cycles_p, 4, free-running clock cycles after unpark before ready_o (>=1)

Ports:
- clk_i  in  1  core clock; all state except negedge clock flops on posedge
- reset_n_i  in  1  asynchronous active-low reset
- train_i  in  1  request retraining; level, sampled each posedge
- park_en_i  in  1  enables idle clock parking
- valid_i  in  1  upstream word valid
- data_i  in  channels_p*width_p  upstream word; channel c = bits [c*width_p +: width_p]
- ready_o  out  1  word accepted when valid_i & ready_o
- clk_o  out  channels_p  forwarded clock per channel
- valid_o  out  channels_p  per-channel valid, all bits identical
- data_o  out  channels_p*width_p  registered pad data
- link_up_o  out  1  high in ACTIVE, PARKED and WAKE

Behaviour:
- Reset is asynchronous, active low. While reset_n_i=0 and at release: state=TRAIN, counters 0, data_o=0, valid_o=0, ready_o=0, link_up_o=0, all clock toggle flops 0, clk_o=0.
- FSM states: TRAIN, ACTIVE, PARKED, WAKE.
- TRAIN
  - clock enabled; valid_o=0.
  - Pad data on cycle n of the episode (n=0..train_cycles_p-1): data_o bit i of every channel = (n+i)&1.
  - After cycle train_cycles_p-1 -> ACTIVE; data_o then holds its last training value.
- ACTIVE
  - ready_o = ~train_i.
  - On valid_i & ready_o: data_o <= data_i and valid_o <= all-ones on the next posedge (latency 1). Otherwise valid_o <= 0 and data_o holds.
  - The idle counter increments on every cycle without a transfer and clears on a transfer.
  - When the idle counter = idle_cycles_p-1, park_en_i=1 and valid_i=0 -> PARKED.
- PARKED
  - clock enable=0; ready_o=0; valid_o=0; data_o holds.
  - valid_i=1 -> WAKE; the word is not accepted.
- WAKE
  - clock enabled; ready_o=0; valid_o=0.
  - After wake_cycles_p cycles -> ACTIVE; the pending valid_i is then accepted normally.
- train_i=1 in any state -> TRAIN on the next posedge with the episode counter at 0.
  - train_i held high repeats cycle 0; the episode starts when train_i drops.
  - train_i wins over the park and wake transitions.
- Forwarded clock, per channel:
  - clk_en_r is registered at posedge from the next state; it is enabled in TRAIN, ACTIVE and WAKE.
  - The posedge flop p toggles when clk_en_r=1.
  - A negedge flop copies clk_en_r into en_n; the negedge flop n toggles when en_n=1.
  - clk_o = p ^ n: high from posedge to negedge, one pulse per clk_i cycle, centred on the data eye for the receiver.
  - Disabling stops p and n at equal values, so clk_o parks low glitch-free. Re-enabling resumes with a full first pulse.
- No data is lost or duplicated across the park/wake and train transitions.
- Counters are $clog2 sized and saturate at their terminal value; they never wrap.

Decomposition:
- Package bsg_link_osdr_pkg: state enum (TRAIN, ACTIVE, PARKED, WAKE) and the training-pattern function.
- Sub-module bsg_link_osdr_clk_gen: p/n toggle flops plus XOR, instantiated per channel. Hardened cells are dont_touch-wrapped at the integration layer only.

Test Plan:
- Release reset with train_cycles_p=64 -> data_o toggles 0x5555/0xAAAA per channel for 64 cycles, valid_o=0; ready_o=1 on cycle 65; clk_o pulses once every cycle from the first posedge.
- Back-to-back stream 0x0001..0x0010 on both channels -> each word appears on data_o one cycle after acceptance with valid_o=2'b11; no bubbles; idle counter stays 0.
- park_en_i=1, valid_i=0 for 16 cycles -> PARKED; clk_o stuck low with no runt pulse. Then valid_i=1 with 0xBEEF -> 4 clock pulses with ready_o=0, then 0xBEEF is accepted and driven exactly once.
- train_i pulsed while streaming -> ready_o drops in the same cycle, full 64-cycle pattern, then ACTIVE. No word is dropped: the upstream holds valid_i, and the held word emerges after training.
- reset_n_i asserted mid-transfer and mid-clock-pulse -> all outputs 0 immediately (asynchronously), clk_o low; recovery repeats the full training.
- park_en_i=0 with a long idle period -> never parks; clk_o runs continuously.

Source files
------------

// File: rtl/bsg_link_osdr_pkg.sv
// Shared types and helpers for the multi-channel source-synchronous SDR output PHY.
package bsg_link_osdr_pkg;

    typedef enum logic [1:0] {
        TRAIN  = 2'd0,
        ACTIVE = 2'd1,
        PARKED = 2'd2,
        WAKE   = 2'd3
    } state_e;

    // Training pattern bit i on episode cycle n is (n+i)&1, so only the LSBs matter.
    function automatic logic train_bit(input logic cycle_lsb, input int bit_idx);
        return cycle_lsb ^ bit_idx[0];
    endfunction

    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/bsg_link_osdr_clk_gen.sv
// Forwarded-clock generator: a posedge and a negedge toggle flop XORed into one
// pulse per core cycle, high from posedge to negedge.
module bsg_link_osdr_clk_gen (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clk_en_i,
    output logic clk_o
);

    logic p_r;
    logic n_r;
    logic en_n_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            p_r <= 1'b0;
        end else if (clk_en_i) begin
            p_r <= ~p_r;
        end
    end

    // The enable reaches the negedge flop half a cycle late, so p and n always stop equal.
    always_ff @(negedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            en_n_r <= 1'b0;
            n_r    <= 1'b0;
        end else begin
            en_n_r <= clk_en_i;
            if (en_n_r) begin
                n_r <= ~n_r;
            end
        end
    end

    assign clk_o = p_r ^ n_r;

endmodule

// File: rtl/bsg_link_osdr_phy_multi.sv
// Multi-channel SDR output PHY with link training, idle clock parking and wake-up.
module bsg_link_osdr_phy_multi
    import bsg_link_osdr_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int channels_p     = 2,
    parameter int train_cycles_p = 64,
    parameter int idle_cycles_p  = 16,
    parameter int wake_cycles_p  = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           train_i,
    input  logic                           park_en_i,
    input  logic                           valid_i,
    input  logic [channels_p*width_p-1:0]  data_i,
    output logic                           ready_o,
    output logic [channels_p-1:0]          clk_o,
    output logic [channels_p-1:0]          valid_o,
    output logic [channels_p*width_p-1:0]  data_o,
    output logic                           link_up_o
);

    localparam int train_cnt_w = cnt_width(train_cycles_p);
    localparam int idle_cnt_w  = cnt_width(idle_cycles_p);
    localparam int wake_cnt_w  = cnt_width(wake_cycles_p);

    localparam logic [train_cnt_w-1:0] train_last = train_cnt_w'(train_cycles_p - 1);
    localparam logic [idle_cnt_w-1:0]  idle_last  = idle_cnt_w'(idle_cycles_p - 1);
    localparam logic [wake_cnt_w-1:0]  wake_last  = wake_cnt_w'(wake_cycles_p - 1);

    state_e                  state_r, state_n;
    logic [train_cnt_w-1:0]  train_cnt_r, train_cnt_n;
    logic [idle_cnt_w-1:0]   idle_cnt_r, idle_cnt_n;
    logic [wake_cnt_w-1:0]   wake_cnt_r, wake_cnt_n;
    logic                    clk_en_r;
    logic                    xfer;
    logic [channels_p*width_p-1:0] train_word;

    assign ready_o   = (state_r == ACTIVE) & ~train_i;
    assign xfer      = ready_o & valid_i;
    assign link_up_o = (state_r != TRAIN);

    always_comb begin
        train_word = '0;
        for (int c = 0; c < channels_p; c++) begin
            for (int i = 0; i < width_p; i++) begin
                train_word[c*width_p + i] = train_bit(train_cnt_r[0], i);
            end
        end
    end

    // Counters not owned by the current state fall back to zero; train_i overrides everything.
    always_comb begin
        state_n     = state_r;
        train_cnt_n = '0;
        idle_cnt_n  = '0;
        wake_cnt_n  = '0;
        unique case (state_r)
            TRAIN: begin
                if (train_cnt_r == train_last) begin
                    state_n = ACTIVE;
                end else begin
                    train_cnt_n = train_cnt_r + 1'b1;
                end
            end
            ACTIVE: begin
                if (xfer) begin
                    idle_cnt_n = '0;
                end else if (idle_cnt_r != idle_last) begin
                    idle_cnt_n = idle_cnt_r + 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt_r;
                end
                if ((idle_cnt_r == idle_last) && park_en_i && !valid_i) begin
                    state_n = PARKED;
                end
            end
            PARKED: begin
                if (valid_i) begin
                    state_n = WAKE;
                end
            end
            WAKE: begin
                if (wake_cnt_r == wake_last) begin
                    state_n = ACTIVE;
                end else begin
                    wake_cnt_n = wake_cnt_r + 1'b1;
                end
            end
            default: state_n = TRAIN;
        endcase
        if (train_i) begin
            state_n     = TRAIN;
            train_cnt_n = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= TRAIN;
            train_cnt_r <= '0;
            idle_cnt_r  <= '0;
            wake_cnt_r  <= '0;
            clk_en_r    <= 1'b0;
        end else begin
            state_r     <= state_n;
            train_cnt_r <= train_cnt_n;
            idle_cnt_r  <= idle_cnt_n;
            wake_cnt_r  <= wake_cnt_n;
            clk_en_r    <= (state_n != PARKED);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o  <= '0;
            valid_o <= '0;
        end else begin
            valid_o <= {channels_p{xfer}};
            if (state_r == TRAIN) begin
                data_o <= train_word;
            end else if (xfer) begin
                data_o <= data_i;
            end
        end
    end

    for (genvar c = 0; c < channels_p; c++) begin : g_chan
        bsg_link_osdr_clk_gen u_clk_gen (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .clk_en_i  (clk_en_r),
            .clk_o     (clk_o[c])
        );
    end

endmodule

// File: tb/tb_bsg_link_osdr_phy_multi.sv
// Scoreboard bench for bsg_link_osdr_phy_multi: words issued are queued, a monitor
// pops and compares whenever valid_o is presented.
module tb_bsg_link_osdr_phy_multi;

    localparam int W = 16;
    localparam int C = 2;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic           train_i;
    logic           park_en_i;
    logic           valid_i;
    logic [C*W-1:0] data_i;
    logic           ready_o;
    logic [C-1:0]   clk_o;
    logic [C-1:0]   valid_o;
    logic [C*W-1:0] data_o;
    logic           link_up_o;

    int             totalChecks = 0;
    int             badChecks   = 0;
    int             pulseCnt    = 0;
    longint         riseTime    = 0;
    logic [C*W-1:0] expQ[$];

    bsg_link_osdr_phy_multi #(
        .width_p        (W),
        .channels_p     (C),
        .train_cycles_p (64),
        .idle_cycles_p  (16),
        .wake_cycles_p  (4)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .train_i   (train_i),
        .park_en_i (park_en_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .clk_o     (clk_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .link_up_o (link_up_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one word; queue its expected output only when it is meant to be accepted.
    task automatic applyStimulus(input logic [W-1:0] word, input bit expectAccept);
        valid_i = 1'b1;
        data_i  = {C{word}};
        if (expectAccept) expQ.push_back({C{word}});
    endtask

    task automatic checkTraining(input bit validHeld);
        logic [W-1:0] pat;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk_i);
            pat = (n % 2 == 0) ? 16'hAAAA : 16'h5555;
            checkOutput("train pattern", {29'd0, ready_o, valid_o, data_o},
                        {29'd0, (n == 63) ? 1'b1 : 1'b0, 2'b00, pat, pat});
        end
        checkOutput("link_up after train", {63'd0, link_up_o}, 64'd1);
        if (validHeld) checkOutput("ready with held word", {63'd0, ready_o}, 64'd1);
    endtask

    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1 && valid_o !== 2'b00) begin
            if (expQ.size() == 0) begin
                totalChecks++;
                badChecks++;
                $display("[TB] FAIL unexpected word: actual=%0h expected none", data_o);
            end else begin
                logic [C*W-1:0] exp;
                exp = expQ.pop_front();
                checkOutput("out word", {30'd0, valid_o, data_o}, {30'd0, 2'b11, exp});
            end
        end
    end

    always @(posedge clk_o[0]) begin
        riseTime = $time;
        pulseCnt++;
    end

    always @(negedge clk_o[0]) begin
        if (reset_n_i === 1'b1) checkOutput("clk_o high width", 64'($time - riseTime), 64'd5);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n_i = 1'b0;
        train_i   = 1'b0;
        park_en_i = 1'b0;
        valid_i   = 1'b0;
        data_i    = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("reset outputs", {27'd0, ready_o, link_up_o, clk_o, valid_o, data_o}, 64'd0);

        $display("[TB] training after reset");
        reset_n_i = 1'b1;
        checkTraining(1'b0);

        $display("[TB] long idle without parking");
        pulseCnt = 0;
        repeat (40) @(negedge clk_i);
        checkOutput("idle pulses", 64'(pulseCnt), 64'd40);
        checkOutput("idle no park", {62'd0, link_up_o, ready_o}, 64'd3);

        $display("[TB] back-to-back stream");
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(W'(k), 1'b1);
            #1 checkOutput("stream ready", {63'd0, ready_o}, 64'd1);
            @(negedge clk_i);
        end
        valid_i   = 1'b0;
        park_en_i = 1'b1;

        $display("[TB] park after 16 idle cycles");
        for (int m = 1; m <= 15; m++) begin
            @(negedge clk_i);
            checkOutput("pre-park ready", {63'd0, ready_o}, 64'd1);
        end
        @(negedge clk_i);
        checkOutput("parked", {62'd0, link_up_o, ready_o}, 64'd2);
        pulseCnt = 0;
        repeat (10) @(negedge clk_i);
        checkOutput("parked pulses", 64'(pulseCnt), 64'd0);
        checkOutput("parked clk_o", {62'd0, clk_o}, 64'd0);

        $display("[TB] wake with pending word");
        applyStimulus(16'hBEEF, 1'b1);
        pulseCnt = 0;
        #1 checkOutput("parked ready", {63'd0, ready_o}, 64'd0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_i);
            checkOutput("wake ready", {63'd0, ready_o}, 64'd0);
        end
        @(negedge clk_i);
        checkOutput("ready after wake", {63'd0, ready_o}, 64'd1);
        checkOutput("wake pulses", 64'(pulseCnt), 64'd4);
        @(negedge clk_i);
        valid_i   = 1'b0;
        park_en_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] retrain while streaming");
        applyStimulus(16'h1234, 1'b1);
        #1 checkOutput("ready before train", {63'd0, ready_o}, 64'd1);
        @(negedge clk_i);
        applyStimulus(16'h5678, 1'b1);
        train_i = 1'b1;
        #1 checkOutput("ready drops on train", {63'd0, ready_o}, 64'd0);
        @(negedge clk_i);
        train_i = 1'b0;
        checkTraining(1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);

        $display("[TB] reset mid-transfer and mid-pulse");
        applyStimulus(16'hC0DE, 1'b0);
        @(posedge clk_i);
        #2 checkOutput("clk_o high mid-pulse", {62'd0, clk_o}, 64'd3);
        reset_n_i = 1'b0;
        #1 checkOutput("async reset outputs", {27'd0, ready_o, link_up_o, clk_o, valid_o, data_o}, 64'd0);
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        checkTraining(1'b0);

        repeat (3) @(negedge clk_i);
        checkOutput("queue drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
